// File: rtl/fifo_push_credit_pkg.sv
// Shared types and helpers for the push-side credit scheduler of the CDC flop-RAM FIFO.
package fifo_push_credit_pkg;

    typedef enum logic [1:0] {
        PS_INIT   = 2'd0,
        PS_ACTIVE = 2'd1,
        PS_HOLD   = 2'd2
    } push_state_e;

    localparam int CREDITS_DEF = 16;
    localparam int DATA_W_DEF  = 8;

    // Credits left over once the withheld reserve is removed; never goes below zero.
    function automatic logic [31:0] credit_sat_sub(input logic [31:0] count,
                                                   input logic [31:0] withhold);
        return (count > withhold) ? (count - withhold) : 32'd0;
    endfunction

endpackage

// File: rtl/fifo_push_credit_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after the pointer wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W:0]   lane_sum [NUM_REQ];
    logic [IDX_W-1:0] lane_idx [NUM_REQ];
    logic [NUM_REQ-1:0] req_rot;

    // req_rot[k] is the request k positions after the pointer, wrapped modulo NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        assign lane_sum[gi] = {1'b0, pointer} + (IDX_W+1)'(gi);
        assign lane_idx[gi] = (lane_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                            ? IDX_W'(lane_sum[gi] - (IDX_W+1)'(NUM_REQ))
                            : IDX_W'(lane_sum[gi]);
        assign req_rot[gi]  = req[lane_idx[gi]];
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_any = 1'b1;
                grant_idx = lane_idx[k];
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_push_credit_arbiter.sv
// Push-side scheduler: round-robin over requesters, gated by FIFO credits, init window and stall.
// Optional build macro CREDIT_ERR_CHECK_EN adds a sticky credit_err output and a one-hot grant assertion.
module fifo_push_credit_arbiter
    import fifo_push_credit_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CREDITS     = CREDITS_DEF,
    parameter int CNT_W       = $clog2(CREDITS + 1),
    parameter int INIT_CYCLES = 4,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                      push_clk,
    input  logic                      push_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      push_valid,
    output logic [DATA_W-1:0]         push_data,
    input  logic                      push_credit_return,
    input  logic                      push_credit_stall,
    input  logic [CNT_W-1:0]          credit_withhold,
    output logic                      push_sender_in_reset,
    output logic [CNT_W-1:0]          credit_count_push,
    output logic [CNT_W-1:0]          credit_available_push,
    output logic [IDX_W-1:0]          grant_id
`ifdef CREDIT_ERR_CHECK_EN
    ,
    output logic                      credit_err
`endif
);

    localparam logic [1:0] S_INIT   = PS_INIT;
    localparam logic [1:0] S_ACTIVE = PS_ACTIVE;
    localparam logic [1:0] S_HOLD   = PS_HOLD;
    localparam int         INIT_W   = $clog2(INIT_CYCLES + 1);

    logic [1:0]        state_reg, state_next;
    logic [INIT_W-1:0] init_cnt_reg, init_cnt_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [IDX_W-1:0]  grant_id_reg;
    logic              push_valid_reg;
    logic [DATA_W-1:0] push_data_reg;

    logic [DATA_W-1:0]  lane_data [NUM_REQ];
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [CNT_W-1:0]   credit_available;
    logic               grant_en;
    logic               transfer;
    logic               ret_dropped;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane_data[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .pointer   (rr_ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    assign credit_available = CNT_W'(credit_sat_sub(32'(count_reg), 32'(credit_withhold)));
    // Stall is checked directly as well as through HOLD so grants stop in the cycle it rises.
    assign grant_en  = (state_reg == S_ACTIVE) && !push_credit_stall
                    && (credit_available != '0);
    assign transfer  = grant_en && arb_any;
    assign req_ready = transfer ? arb_grant : '0;

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = '0;
        case (state_reg)
            S_INIT: begin
                if (init_cnt_reg == INIT_W'(INIT_CYCLES - 1)) begin
                    state_next = S_ACTIVE;
                end else begin
                    init_cnt_next = init_cnt_reg + INIT_W'(1);
                end
            end
            S_ACTIVE: if (push_credit_stall)  state_next = S_HOLD;
            S_HOLD:   if (!push_credit_stall) state_next = S_ACTIVE;
            default:  state_next = S_INIT;
        endcase
    end

    // Returns while full are dropped; a simultaneous spend and return cancel out.
    always_comb begin
        count_next  = count_reg;
        ret_dropped = 1'b0;
        if (transfer && !push_credit_return) begin
            count_next = count_reg - CNT_W'(1);
        end else if (!transfer && push_credit_return) begin
            if (count_reg == CNT_W'(CREDITS)) begin
                ret_dropped = 1'b1;
            end else begin
                count_next = count_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge push_clk or posedge push_rst) begin
        if (push_rst) begin
            state_reg      <= S_INIT;
            init_cnt_reg   <= '0;
            count_reg      <= CNT_W'(CREDITS);
            rr_ptr_reg     <= '0;
            grant_id_reg   <= '0;
            push_valid_reg <= 1'b0;
            push_data_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            init_cnt_reg   <= init_cnt_next;
            count_reg      <= count_next;
            push_valid_reg <= transfer;
            if (transfer) begin
                push_data_reg <= lane_data[arb_idx];
                grant_id_reg  <= arb_idx;
                rr_ptr_reg    <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
            end
        end
    end

    assign push_valid            = push_valid_reg;
    assign push_data             = push_data_reg;
    assign push_sender_in_reset  = (state_reg == S_INIT);
    assign credit_count_push     = count_reg;
    assign credit_available_push = credit_available;
    assign grant_id              = grant_id_reg;

`ifdef CREDIT_ERR_CHECK_EN
    logic credit_err_reg;

    always_ff @(posedge push_clk or posedge push_rst) begin
        if (push_rst) begin
            credit_err_reg <= 1'b0;
        end else if (ret_dropped) begin
            credit_err_reg <= 1'b1;
        end
    end

    assign credit_err = credit_err_reg;

    a_ready_onehot: assert property (@(posedge push_clk) disable iff (push_rst) $onehot0(req_ready));
`else
    logic unused_ret_dropped;
    assign unused_ret_dropped = ret_dropped;
`endif

endmodule

// File: tb/tb_fifo_push_credit_arbiter.sv
// Directed bench for fifo_push_credit_arbiter: vector table for arbitration order, hand sequences for credit corners.
module tb_fifo_push_credit_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 8;
    localparam int CREDITS     = 16;
    localparam int CNT_W       = 5;
    localparam int INIT_CYCLES = 4;

    logic                      push_clk = 1'b0;
    logic                      push_rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = 32'hD3C2B1A0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      push_valid;
    logic [DATA_W-1:0]         push_data;
    logic                      push_credit_return = 1'b0;
    logic                      push_credit_stall = 1'b0;
    logic [CNT_W-1:0]          credit_withhold = '0;
    logic                      push_sender_in_reset;
    logic [CNT_W-1:0]          credit_count_push;
    logic [CNT_W-1:0]          credit_available_push;
    logic [1:0]                grant_id;
`ifdef CREDIT_ERR_CHECK_EN
    logic                      credit_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 push_clk = ~push_clk;

    fifo_push_credit_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .CREDITS     (CREDITS),
        .CNT_W       (CNT_W),
        .INIT_CYCLES (INIT_CYCLES)
    ) dut (
        .push_clk              (push_clk),
        .push_rst              (push_rst),
        .req_valid             (req_valid),
        .req_data              (req_data),
        .req_ready             (req_ready),
        .push_valid            (push_valid),
        .push_data             (push_data),
        .push_credit_return    (push_credit_return),
        .push_credit_stall     (push_credit_stall),
        .credit_withhold       (credit_withhold),
        .push_sender_in_reset  (push_sender_in_reset),
        .credit_count_push     (credit_count_push),
        .credit_available_push (credit_available_push),
        .grant_id              (grant_id)
`ifdef CREDIT_ERR_CHECK_EN
        ,
        .credit_err            (credit_err)
`endif
    );

    typedef struct {
        logic [3:0] rv;
        logic [3:0] rdy;
        logic       sir;
        logic       pv;
        logic [7:0] dat;
        logic [4:0] cnt;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench at the first ACTIVE cycle, all inputs idle.
    task automatic do_reset();
        push_rst           = 1'b1;
        req_valid          = '0;
        push_credit_return = 1'b0;
        push_credit_stall  = 1'b0;
        credit_withhold    = '0;
        @(negedge push_clk);
        @(negedge push_clk);
        push_rst = 1'b0;
        repeat (INIT_CYCLES) @(negedge push_clk);
    endtask

    task automatic count_pushes(input int cycles, output int pushes);
        pushes = 0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            if (push_valid === 1'b1) pushes++;
            @(negedge push_clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit hit, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int pushes;
        bit found;

        //        rv     rdy    sir   pv    dat     cnt
        vecs[0]  = '{4'hF, 4'h0, 1'b1, 1'b0, 8'h00, 5'd16};
        vecs[1]  = '{4'hF, 4'h0, 1'b1, 1'b0, 8'h00, 5'd16};
        vecs[2]  = '{4'hF, 4'h0, 1'b1, 1'b0, 8'h00, 5'd16};
        vecs[3]  = '{4'hF, 4'h0, 1'b1, 1'b0, 8'h00, 5'd16};
        vecs[4]  = '{4'hF, 4'h1, 1'b0, 1'b0, 8'h00, 5'd16};
        vecs[5]  = '{4'hF, 4'h2, 1'b0, 1'b1, 8'hA0, 5'd15};
        vecs[6]  = '{4'hF, 4'h4, 1'b0, 1'b1, 8'hB1, 5'd14};
        vecs[7]  = '{4'hF, 4'h8, 1'b0, 1'b1, 8'hC2, 5'd13};
        vecs[8]  = '{4'hF, 4'h1, 1'b0, 1'b1, 8'hD3, 5'd12};
        vecs[9]  = '{4'hF, 4'h2, 1'b0, 1'b1, 8'hA0, 5'd11};
        vecs[10] = '{4'h0, 4'h0, 1'b0, 1'b1, 8'hB1, 5'd10};
        vecs[11] = '{4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 5'd10};
        vecs[12] = '{4'h1, 4'h1, 1'b0, 1'b0, 8'h00, 5'd10};
        vecs[13] = '{4'h8, 4'h8, 1'b0, 1'b1, 8'hA0, 5'd9};
        vecs[14] = '{4'h0, 4'h0, 1'b0, 1'b1, 8'hD3, 5'd8};

        // Reset state while push_rst is held
        @(negedge push_clk);
        #1;
        check("rst_sir", 32'(push_sender_in_reset), 32'd1);
        check("rst_pv", 32'(push_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_count", 32'(credit_count_push), 32'd16);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_data", 32'(push_data), 32'd0);
        @(negedge push_clk);
        push_rst = 1'b0;

        // Init window then round-robin order and rr re-evaluation
        for (int i = 0; i < 15; i++) begin
            req_valid = vecs[i].rv;
            #1;
            $display("vec %0d: req_valid=%b req_ready=%b push_valid=%b push_data=%h count=%0d",
                     i, req_valid, req_ready, push_valid, push_data, credit_count_push);
            check($sformatf("vec%0d_sir", i), 32'(push_sender_in_reset), 32'(vecs[i].sir));
            check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_pv", i), 32'(push_valid), 32'(vecs[i].pv));
            if (vecs[i].pv) check($sformatf("vec%0d_data", i), 32'(push_data), 32'(vecs[i].dat));
            check($sformatf("vec%0d_count", i), 32'(credit_count_push), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_avail", i), 32'(credit_available_push), 32'(vecs[i].cnt));
            @(negedge push_clk);
        end
        #1;
        check("grant_id_last", 32'(grant_id), 32'd3);

        // Credit exhaustion on lane 2, then one returned credit
        do_reset();
        req_valid = 4'b0100;
        count_pushes(30, pushes);
        $display("exhaust: pushes=%0d count=%0d", pushes, credit_count_push);
        check("exhaust_pushes", 32'(pushes), 32'd16);
        #1;
        check("exhaust_count", 32'(credit_count_push), 32'd0);
        check("exhaust_ready", 32'(req_ready), 32'd0);
        check("exhaust_avail", 32'(credit_available_push), 32'd0);
        push_credit_return = 1'b1;
        @(negedge push_clk);
        push_credit_return = 1'b0;
        count_pushes(10, pushes);
        $display("one return: pushes=%0d count=%0d", pushes, credit_count_push);
        check("return_pushes", 32'(pushes), 32'd1);
        #1;
        check("return_count", 32'(credit_count_push), 32'd0);

        // Push and return in the same cycle at count 5
        do_reset();
        req_valid = 4'b0001;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (credit_count_push == 5'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge push_clk);
        end
        check("reach_count5", 32'(found), 32'd1);
        check("simul_ready", 32'(req_ready), 32'd1);
        push_credit_return = 1'b1;
        @(negedge push_clk);
        push_credit_return = 1'b0;
        req_valid = '0;
        #1;
        $display("simul push+return: push_valid=%b count=%0d", push_valid, credit_count_push);
        check("simul_pv", 32'(push_valid), 32'd1);
        check("simul_count", 32'(credit_count_push), 32'd5);

        // Return with no push while full is dropped
        do_reset();
        #1;
        check("full_count_pre", 32'(credit_count_push), 32'd16);
`ifdef CREDIT_ERR_CHECK_EN
        check("credit_err_pre", 32'(credit_err), 32'd0);
`endif
        push_credit_return = 1'b1;
        @(negedge push_clk);
        push_credit_return = 1'b0;
        #1;
        $display("overflow return: count=%0d", credit_count_push);
        check("full_count_post", 32'(credit_count_push), 32'd16);
`ifdef CREDIT_ERR_CHECK_EN
        check("credit_err_post", 32'(credit_err), 32'd1);
`endif

        // Withhold reserves credits
        do_reset();
        credit_withhold = 5'd14;
        #1;
        check("wh14_avail", 32'(credit_available_push), 32'd2);
        req_valid = 4'b0010;
        count_pushes(10, pushes);
        $display("withhold 14: pushes=%0d count=%0d", pushes, credit_count_push);
        check("wh14_pushes", 32'(pushes), 32'd2);
        #1;
        check("wh14_count", 32'(credit_count_push), 32'd14);
        check("wh14_avail_after", 32'(credit_available_push), 32'd0);
        check("wh14_ready", 32'(req_ready), 32'd0);
        credit_withhold = 5'd20;
        #1;
        check("wh20_avail", 32'(credit_available_push), 32'd0);
        check("wh20_ready", 32'(req_ready), 32'd0);
        credit_withhold = 5'd13;
        #1;
        check("wh13_avail", 32'(credit_available_push), 32'd1);
        check("wh13_ready", 32'(req_ready), 32'd2);

        // Stall mid-burst, return during HOLD, resume at saved pointer
        do_reset();
        req_valid = 4'hF;
        #1;
        check("stall_a_ready", 32'(req_ready), 32'd1);
        @(negedge push_clk);
        #1;
        check("stall_b_ready", 32'(req_ready), 32'd2);
        @(negedge push_clk);
        push_credit_stall = 1'b1;
        #1;
        $display("stall raised: req_ready=%b push_valid=%b push_data=%h", req_ready, push_valid, push_data);
        check("stall_c_ready", 32'(req_ready), 32'd0);
        check("stall_c_pv", 32'(push_valid), 32'd1);
        check("stall_c_data", 32'(push_data), 32'hB1);
        check("stall_c_count", 32'(credit_count_push), 32'd14);
        @(negedge push_clk);
        push_credit_return = 1'b1;
        #1;
        check("hold_ready", 32'(req_ready), 32'd0);
        check("hold_pv", 32'(push_valid), 32'd0);
        @(negedge push_clk);
        push_credit_return = 1'b0;
        push_credit_stall  = 1'b0;
        #1;
        check("hold_count", 32'(credit_count_push), 32'd15);
        check("hold_exit_ready", 32'(req_ready), 32'd0);
        @(negedge push_clk);
        #1;
        $display("stall dropped: req_ready=%b count=%0d", req_ready, credit_count_push);
        check("resume_ready", 32'(req_ready), 32'd4);
        @(negedge push_clk);
        #1;
        check("pre_rst_pv", 32'(push_valid), 32'd1);
        check("pre_rst_data", 32'(push_data), 32'hC2);

        // Async reset with a push in flight
        push_rst = 1'b1;
        #1;
        $display("mid reset: push_valid=%b count=%0d sir=%b", push_valid, credit_count_push, push_sender_in_reset);
        check("midrst_pv", 32'(push_valid), 32'd0);
        check("midrst_count", 32'(credit_count_push), 32'd16);
        check("midrst_sir", 32'(push_sender_in_reset), 32'd1);
        check("midrst_ready", 32'(req_ready), 32'd0);
        check("midrst_grant_id", 32'(grant_id), 32'd0);
        @(negedge push_clk);
        push_rst = 1'b0;
        repeat (INIT_CYCLES - 1) @(negedge push_clk);
        #1;
        check("midrst_init_last_sir", 32'(push_sender_in_reset), 32'd1);
        check("midrst_init_last_ready", 32'(req_ready), 32'd0);
        @(negedge push_clk);
        #1;
        check("midrst_active_ready", 32'(req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
